// File: rtl/popcount_acc.sv
// Pipelined ones-counter / correlator: 3:2 full-adder compressor tree feeding a
// block accumulator that reports the total ones count and a signed +/-1 correlation.
module popcount_acc #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 10,
    localparam int CNT_W     = $clog2(DATA_WIDTH + 1),
    localparam int ACC_W     = CNT_W + LEN_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  mode,
    input  logic [LEN_WIDTH-1:0]  acc_len,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [DATA_WIDTH-1:0] in_code,
    output logic                  out_valid,
    output logic [ACC_W-1:0]      out_ones,
    output logic [ACC_W:0]        out_corr
);

    // The word is cut into 3-bit groups, each reduced by one full adder.
    localparam int NG    = (DATA_WIDTH + 2) / 3;
    localparam int PAD_W = NG * 3;

    // Full adder: returns {carry, sum}, i.e. the 2-bit ones count of three bits.
    function automatic logic [1:0] fa(input logic a, input logic b, input logic c);
        fa = {(a & b) | (a & c) | (b & c), a ^ b ^ c};
    endfunction

    // Stage 1 state
    logic                  s1_valid_q, s1_valid_d;
    logic [1:0]            s1_grp_q [NG];
    logic [1:0]            s1_grp_d [NG];
    logic [DATA_WIDTH-1:0] masked_s;
    logic [PAD_W-1:0]      padded_s;

    // Stage 2 state
    logic                  s2_valid_q, s2_valid_d;
    logic [CNT_W-1:0]      s2_cnt_q, s2_cnt_d;
    logic [CNT_W-1:0]      tree_sum_s;

    // Stage 3 / accumulator state
    logic [LEN_WIDTH-1:0]  word_cnt_q, word_cnt_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic                  out_valid_q, out_valid_d;
    logic [ACC_W-1:0]      out_ones_q, out_ones_d;
    logic [ACC_W:0]        out_corr_q, out_corr_d;

    logic [LEN_WIDTH-1:0]  len_in_eff_s;
    logic [LEN_WIDTH-1:0]  blk_len_s;
    logic                  last_s;
    logic [ACC_W-1:0]      acc_sum_s;
    logic [ACC_W:0]        corr_s;

    // Stage 1: apply mode mask and compress each 3-bit group to a 2-bit count.
    always_comb begin
        masked_s   = mode ? (in_data ^ in_code) : in_data;
        padded_s   = PAD_W'(masked_s);
        s1_valid_d = in_valid & ~clear;
        for (int g = 0; g < NG; g++) begin
            if (in_valid) begin
                s1_grp_d[g] = fa(padded_s[3*g], padded_s[3*g+1], padded_s[3*g+2]);
            end else begin
                s1_grp_d[g] = s1_grp_q[g];
            end
        end
    end

    // Stage 2: finish the tree by summing the group counts into the word count.
    always_comb begin
        tree_sum_s = {CNT_W{1'b0}};
        for (int g = 0; g < NG; g++) begin
            tree_sum_s = tree_sum_s + CNT_W'(s1_grp_q[g]);
        end
        s2_valid_d = s1_valid_q & ~clear;
        if (s1_valid_q) begin
            s2_cnt_d = tree_sum_s;
        end else begin
            s2_cnt_d = s2_cnt_q;
        end
    end

    // Stage 3 datapath: block length (sampled on a block's first word), sum and correlation.
    always_comb begin
        len_in_eff_s = (acc_len == {LEN_WIDTH{1'b0}}) ? {{(LEN_WIDTH-1){1'b0}}, 1'b1} : acc_len;
        blk_len_s    = (word_cnt_q == {LEN_WIDTH{1'b0}}) ? len_in_eff_s : len_q;
        last_s       = (word_cnt_q == (blk_len_s - {{(LEN_WIDTH-1){1'b0}}, 1'b1}));
        acc_sum_s    = acc_q + ACC_W'(s2_cnt_q);
        corr_s       = ((ACC_W+1)'(blk_len_s) * (ACC_W+1)'(DATA_WIDTH)) - {acc_sum_s, 1'b0};
    end

    // Stage 3 control: accumulate, close blocks, and honour clear (which beats a closing word).
    always_comb begin
        word_cnt_d  = word_cnt_q;
        len_d       = len_q;
        acc_d       = acc_q;
        out_valid_d = 1'b0;
        out_ones_d  = out_ones_q;
        out_corr_d  = out_corr_q;
        if (clear) begin
            word_cnt_d = {LEN_WIDTH{1'b0}};
            acc_d      = {ACC_W{1'b0}};
        end else if (s2_valid_q) begin
            len_d = blk_len_s;
            if (last_s) begin
                word_cnt_d  = {LEN_WIDTH{1'b0}};
                acc_d       = {ACC_W{1'b0}};
                out_valid_d = 1'b1;
                out_ones_d  = acc_sum_s;
                out_corr_d  = corr_s;
            end else begin
                word_cnt_d = word_cnt_q + {{(LEN_WIDTH-1){1'b0}}, 1'b1};
                acc_d      = acc_sum_s;
            end
        end else begin
            word_cnt_d = word_cnt_q;
        end
    end

    // Pipeline and accumulator registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            for (int g = 0; g < NG; g++) begin
                s1_grp_q[g] <= 2'b00;
            end
            s2_valid_q  <= 1'b0;
            s2_cnt_q    <= {CNT_W{1'b0}};
            word_cnt_q  <= {LEN_WIDTH{1'b0}};
            len_q       <= {LEN_WIDTH{1'b0}};
            acc_q       <= {ACC_W{1'b0}};
            out_valid_q <= 1'b0;
            out_ones_q  <= {ACC_W{1'b0}};
            out_corr_q  <= {(ACC_W+1){1'b0}};
        end else begin
            s1_valid_q  <= s1_valid_d;
            for (int g = 0; g < NG; g++) begin
                s1_grp_q[g] <= s1_grp_d[g];
            end
            s2_valid_q  <= s2_valid_d;
            s2_cnt_q    <= s2_cnt_d;
            word_cnt_q  <= word_cnt_d;
            len_q       <= len_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_ones_q  <= out_ones_d;
            out_corr_q  <= out_corr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_ones  = out_ones_q;
    assign out_corr  = out_corr_q;

endmodule

// File: tb/tb_popcount_acc.sv
// Self-checking bench for popcount_acc: vector table plus multi-cycle sequences,
// with expected block results queued at drive time and compared when out_valid fires.
module tb_popcount_acc;

    typedef struct {
        logic        mode;
        logic [31:0] data;
        logic [31:0] code;
        int          ones;
        int          corr;
    } vec_t;

    typedef struct {
        int cyc;
        int ones;
        int corr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, clear, mode, in_valid;
    logic [9:0]  acc_len;
    logic [31:0] in_data, in_code;
    logic        out_valid;
    logic [15:0] out_ones;
    logic [16:0] out_corr;

    int   passed = 0;
    int   total  = 0;
    int   cyc    = 0;
    exp_t sb[$];
    vec_t vecs[8];

    popcount_acc #(.DATA_WIDTH(32), .LEN_WIDTH(10)) dut (
        .clk(clk), .rst(rst), .clear(clear), .mode(mode), .acc_len(acc_len),
        .in_valid(in_valid), .in_data(in_data), .in_code(in_code),
        .out_valid(out_valid), .out_ones(out_ones), .out_corr(out_corr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic check_out();
        exp_t e;
        if (out_valid) begin
            if (sb.size() == 0) begin
                chk("spurious out_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("pulse cycle", cyc, e.cyc);
                chk("out_ones", int'(out_ones), e.ones);
                chk("out_corr", int'($signed(out_corr)), e.corr);
            end
        end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            chk("missing out_valid", 0, 1);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_out();
    endtask

    task automatic word(input logic [31:0] d, input logic [31:0] c,
                        input bit push, input int ones, input int corr);
        exp_t e;
        in_valid = 1'b1;
        in_data  = d;
        in_code  = c;
        if (push) begin
            e.cyc = cyc + 3; e.ones = ones; e.corr = corr;
            sb.push_back(e);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int   k;
        int   acc;
        logic m;
        logic [31:0] d, c;

        vecs[0] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 32, -32};
        vecs[1] = '{1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 0, 32};
        vecs[2] = '{1'b1, 32'hFFFF_0000, 32'h0000_FFFF, 32, -32};
        vecs[3] = '{1'b1, 32'h1234_5678, 32'h1234_5678, 0, 32};
        vecs[4] = '{1'b0, 32'h0000_000F, 32'hFFFF_FFFF, 4, 24};
        vecs[5] = '{1'b0, 32'h8000_0001, 32'h0000_0000, 2, 28};
        vecs[6] = '{1'b1, 32'hF0F0_F0F0, 32'h0000_0000, 16, 0};
        vecs[7] = '{1'b0, 32'h5555_5555, 32'h0F0F_0F0F, 16, 0};

        rst = 1'b1; clear = 1'b0; mode = 1'b0; in_valid = 1'b0;
        acc_len = 10'd1; in_data = 32'd0; in_code = 32'd0;
        idle(3);
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset out_ones", int'(out_ones), 0);
        chk("reset out_corr", int'(out_corr), 0);
        rst = 1'b0;
        idle(2);

        // acc_len=1 vectors back to back: one pulse per word, every cycle
        acc_len = 10'd1;
        for (int i = 0; i < 8; i++) begin
            mode = vecs[i].mode;
            word(vecs[i].data, vecs[i].code, 1'b1, vecs[i].ones, vecs[i].corr);
        end
        idle(4);

        // mode 1, four matching words: zero mismatches
        mode = 1'b1; acc_len = 10'd4;
        for (int i = 0; i < 4; i++) word(32'hA5A5_A5A5, 32'hA5A5_A5A5, i == 3, 0, 128);
        idle(4);

        // gaps in in_valid: accumulator holds across idle cycles
        mode = 1'b0; acc_len = 10'd3;
        word(32'h0000_000F, 32'h0, 1'b0, 0, 0);
        idle(2);
        word(32'h0000_000F, 32'h0, 1'b0, 0, 0);
        word(32'h0000_000F, 32'h0, 1'b1, 12, 72);
        idle(4);

        // back-to-back blocks of two
        acc_len = 10'd2;
        for (int i = 0; i < 4; i++) word(32'h0000_0001, 32'h0, i % 2 == 1, 2, 60);
        idle(4);

        // clear coinciding with the closing word in stage 3: no pulse, results held
        word(32'h0000_0007, 32'h0, 1'b0, 0, 0);
        word(32'h0000_0007, 32'h0, 1'b0, 0, 0);
        idle(1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clear-last no pulse", int'(out_valid), 0);
        idle(3);
        chk("hold out_ones after clear", int'(out_ones), 2);
        chk("hold out_corr after clear", int'($signed(out_corr)), 60);

        // clear mid-block then a full block
        acc_len = 10'd4;
        word(32'h0000_0003, 32'h0, 1'b0, 0, 0);
        word(32'h0000_0003, 32'h0, 1'b0, 0, 0);
        clear = 1'b1;
        word(32'h0000_0003, 32'h0, 1'b0, 0, 0);
        clear = 1'b0;
        for (int i = 0; i < 4; i++) word(32'h0000_0003, 32'h0, i == 3, 8, 112);
        idle(4);

        // acc_len=0 behaves as 1
        acc_len = 10'd0;
        for (int i = 0; i < 3; i++) word(32'h0000_00FF, 32'h0, 1'b1, 8, 16);
        idle(4);

        // rst mid-block: outputs zeroed, aborted block never reported
        acc_len = 10'd4;
        word(32'hFFFF_FFFF, 32'h0, 1'b0, 0, 0);
        word(32'hFFFF_FFFF, 32'h0, 1'b0, 0, 0);
        rst = 1'b1;
        word(32'hFFFF_FFFF, 32'h0, 1'b0, 0, 0);
        rst = 1'b0;
        chk("rst out_valid", int'(out_valid), 0);
        chk("rst out_ones", int'(out_ones), 0);
        chk("rst out_corr", int'(out_corr), 0);
        idle(5);

        // random words with gaps, acc_len=3
        acc_len = 10'd3;
        k = 0; acc = 0;
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 2) != 0) begin
                m = 1'($urandom_range(0, 1));
                d = $urandom;
                c = $urandom;
                mode = m;
                acc = acc + $countones(m ? (d ^ c) : d);
                k++;
                word(d, c, k % 3 == 0, acc, 96 - 2 * acc);
                if (k % 3 == 0) acc = 0;
            end else begin
                idle(1);
            end
        end
        // a trailing partial block is aborted so it cannot leak into the next test
        idle(3);
        clear = 1'b1; tick(); clear = 1'b0;
        idle(3);

        // longest block, all ones
        mode = 1'b0; acc_len = 10'd1023;
        for (int i = 0; i < 1023; i++) word(32'hFFFF_FFFF, 32'h0, i == 1022, 32736, -32736);
        idle(8);
        chk("scoreboard empty", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
